// File: rtl/dii_packet_arbiter_pkg.sv
// rtl/dii_packet_arbiter_pkg.sv - shared types for the DII packet arbiter
// Contents:
//   state_e      : arbiter lock state (ST_IDLE arbitrates, ST_LOCKED holds a packet)
//   DII_MAX_N    : largest supported number of input channels
//   rr_next_idx  : round-robin successor of a channel index, wrapping at n
package dii_packet_arbiter_pkg;

  localparam int DII_MAX_N = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic int rr_next_idx(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/dii_rr_select.sv
// rtl/dii_rr_select.sv - combinational round-robin request selector
// Ports:
//   req       in  [N-1:0]  request per channel
//   rr_ptr    in  [IW-1:0] highest-priority channel this cycle
//   grant     out [N-1:0]  one-hot grant (all zero when no request)
//   grant_idx out [IW-1:0] binary grant index (rr_ptr when no request)
//   any_req   out          at least one request present
module dii_rr_select #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    any_req   = |req;
    // Walk offsets from farthest to nearest so the closest requester at or
    // above rr_ptr (with wrap) is the last one written and therefore wins.
    for (int k = N - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr) + k) % N;
      if (req[idx]) begin
        grant_idx = IW'(idx);
      end
    end
    if (any_req) begin
      grant[grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/dii_packet_arbiter.sv
// rtl/dii_packet_arbiter.sv - N-to-1 DII packet arbiter, whole packets, round-robin
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_data  [N*WIDTH]    channel i flit data at [i*WIDTH +: WIDTH]
//   in_first/in_last [N]  per-channel flit markers
//   in_valid/in_ready [N] per-channel handshake
//   out_data/first/last   selected channel's flit, passed through
//   out_valid/out_ready   downstream handshake
//   grant_id              currently selected channel
//   locked                a multi-flit packet is in progress
module dii_packet_arbiter
  import dii_packet_arbiter_pkg::*;
#(
  parameter  int N     = 2,
  parameter  int WIDTH = 16,
  localparam int IW    = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_first,
  input  logic [N-1:0]         in_last,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_first,
  output logic                 out_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        grant_id,
  output logic                 locked
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             first;
    logic             last;
  } dii_flit_t;

  state_e        state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] lock_id_q, lock_id_d;

  logic [N-1:0]  rr_grant;
  logic [IW-1:0] rr_idx;
  logic          rr_any;
  logic [IW-1:0] sel_idx;
  dii_flit_t     flit_sel;
  logic          xfer;

  dii_rr_select #(.N(N)) u_rr_select (
    .req       (in_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (rr_grant),
    .grant_idx (rr_idx),
    .any_req   (rr_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_id_q <= lock_id_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    lock_id_d = lock_id_q;
    if (xfer) begin
      if (flit_sel.last) begin
        // Packet done: release and hand priority to the next channel up.
        state_d  = ST_IDLE;
        rr_ptr_d = IW'(rr_next_idx(int'(sel_idx), N));
      end else begin
        state_d   = ST_LOCKED;
        lock_id_d = sel_idx;
      end
    end
  end

  always_comb begin
    sel_idx  = (state_q == ST_LOCKED) ? lock_id_q : rr_idx;
    flit_sel = '{data:  in_data[sel_idx*WIDTH +: WIDTH],
                 first: in_first[sel_idx],
                 last:  in_last[sel_idx]};
    in_ready = '0;
    if (state_q == ST_LOCKED) begin
      // Locked channel is offered ready regardless of its own valid; others wait.
      out_valid         = in_valid[sel_idx];
      in_ready[sel_idx] = out_ready;
    end else begin
      out_valid = rr_any;
      in_ready  = {N{out_ready}} & rr_grant;
    end
    xfer      = out_valid & out_ready;
    out_data  = flit_sel.data;
    out_first = flit_sel.first;
    out_last  = flit_sel.last;
    grant_id  = sel_idx;
    locked    = (state_q == ST_LOCKED);
  end

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// tb/tb_dii_packet_arbiter.sv - self-checking bench for dii_packet_arbiter
module tb_dii_packet_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  typedef logic [W+1:0] flit_t;  // {first, last, data}

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_first = '0;
  logic [N-1:0]   in_last = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_first;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     grant_id;
  logic           locked;

  dii_packet_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    seq      = 0;
  flit_t chq [N][$];
  int    grant_log[$];

  // Reference model: packet-level arbiter state.
  int m_rr      = 0;
  bit m_locked  = 0;
  int m_lock_id = 0;

  task automatic push_pkt(input int ch, input int len);
    for (int k = 0; k < len; k++) begin
      flit_t f;
      f[W-1:0] = {4'(ch), 12'(seq)};
      f[W+1]   = (k == 0);
      f[W]     = (k == len - 1);
      chq[ch].push_back(f);
      seq++;
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) chq[i].delete();
    grant_log.delete();
  endtask

  task automatic run_cycle(input string name, input logic ordy,
                           input logic [N-1:0] gate, input logic do_rst);
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    flit_t        f;
    int           g;
    bit           found;
    bit           xf;
    @(negedge clk);
    rst       = do_rst;
    out_ready = ordy;
    for (int i = 0; i < N; i++) begin
      v[i] = gate[i] && (chq[i].size() > 0);
      f    = v[i] ? chq[i][0] : '0;
      in_data[i*W +: W] = f[W-1:0];
      in_first[i]       = f[W+1];
      in_last[i]        = f[W];
    end
    in_valid = v;
    #1;
    if (m_locked) begin
      g = m_lock_id;
    end else begin
      g     = m_rr;
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && v[(m_rr + k) % N]) begin
          g     = (m_rr + k) % N;
          found = 1;
        end
      end
    end
    exp_rdy = '0;
    if (m_locked || v[g]) exp_rdy[g] = ordy;
    xf = v[g] && ordy;

    n_checks++;
    if (out_valid !== v[g]) begin
      n_fail++;
      $display("FAIL %s out_valid got %b want %b", name, out_valid, v[g]);
    end
    n_checks++;
    if (grant_id !== 2'(g)) begin
      n_fail++;
      $display("FAIL %s grant_id got %0d want %0d", name, grant_id, g);
    end
    n_checks++;
    if (locked !== m_locked) begin
      n_fail++;
      $display("FAIL %s locked got %b want %b", name, locked, m_locked);
    end
    n_checks++;
    if (in_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s in_ready got %b want %b", name, in_ready, exp_rdy);
    end
    if (v[g]) begin
      f = chq[g][0];
      n_checks++;
      if ({out_first, out_last, out_data} !== f) begin
        n_fail++;
        $display("FAIL %s out_flit got %h want %h", name,
                 {out_first, out_last, out_data}, f);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) grant_log.push_back(int'(grant_id));

    @(posedge clk);
    if (xf) begin
      f = chq[g].pop_front();
      if (f[W]) begin
        m_locked = 0;
        m_rr     = (g + 1) % N;
      end else begin
        m_locked  = 1;
        m_lock_id = g;
      end
    end
    if (do_rst) begin
      m_locked  = 0;
      m_rr      = 0;
      m_lock_id = 0;
    end
  endtask

  task automatic do_reset();
    clear_all();
    run_cycle("reset", 1'b0, '0, 1'b1);
    grant_log.delete();
  endtask

  task automatic check_log(input string name, input int exp[$]);
    n_checks++;
    if (grant_log.size() != exp.size()) begin
      n_fail++;
      $display("FAIL %s log_len got %0d want %0d", name, grant_log.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_checks++;
        if (grant_log[i] != exp[i]) begin
          n_fail++;
          $display("FAIL %s order[%0d] got %0d want %0d", name, i, grant_log[i], exp[i]);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    int left;
    left = 0;
    for (int i = 0; i < N; i++) left += chq[i].size();
    n_checks++;
    if (left != 0) begin
      n_fail++;
      $display("FAIL %s flits_left got %0d want 0", name, left);
    end
  endtask

  task automatic test_reset();
    clear_all();
    run_cycle("reset_idle", 1'b1, '1, 1'b1);
    run_cycle("reset_idle", 1'b1, '1, 1'b1);
    run_cycle("after_reset", 1'b1, '1, 1'b0);
  endtask

  task automatic test_single_packet();
    do_reset();
    push_pkt(2, 3);
    repeat (3) run_cycle("single_ch2", 1'b1, '1, 1'b0);
    run_cycle("single_ch2_ptr", 1'b1, '1, 1'b0);
    check_log("single_ch2", '{2, 2, 2});
    check_drained("single_ch2");
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) push_pkt(i, 1);
    repeat (12) run_cycle("round_robin", 1'b1, '1, 1'b0);
    check_log("round_robin", '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3});
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_pkt(0, 4);
    push_pkt(1, 2);
    run_cycle("back_to_back", 1'b1, 4'b0001, 1'b0);
    repeat (5) run_cycle("back_to_back", 1'b1, '1, 1'b0);
    check_log("back_to_back", '{0, 0, 0, 0, 1, 1});
  endtask

  task automatic test_backpressure();
    do_reset();
    push_pkt(1, 2);
    push_pkt(0, 1);
    run_cycle("backpressure", 1'b1, 4'b0010, 1'b0);
    run_cycle("backpressure", 1'b0, 4'b0011, 1'b0);
    run_cycle("backpressure", 1'b1, 4'b0011, 1'b0);
    run_cycle("backpressure", 1'b0, 4'b0011, 1'b0);
    run_cycle("backpressure", 1'b1, 4'b0011, 1'b0);
    check_log("backpressure", '{1, 1, 0});
  endtask

  task automatic test_valid_drop();
    do_reset();
    push_pkt(3, 3);
    push_pkt(0, 1);
    run_cycle("valid_drop", 1'b1, 4'b1000, 1'b0);
    run_cycle("valid_drop", 1'b1, 4'b0001, 1'b0);
    run_cycle("valid_drop", 1'b1, 4'b0001, 1'b0);
    repeat (3) run_cycle("valid_drop", 1'b1, 4'b1001, 1'b0);
    check_log("valid_drop", '{3, 3, 3, 0});
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push_pkt(1, 3);
    push_pkt(0, 1);
    run_cycle("rst_mid_pkt", 1'b1, 4'b0010, 1'b0);
    run_cycle("rst_mid_pkt", 1'b1, 4'b0011, 1'b1);
    run_cycle("rst_mid_pkt", 1'b1, 4'b0011, 1'b0);
    run_cycle("rst_mid_pkt", 1'b1, 4'b0011, 1'b0);
    check_log("rst_mid_pkt", '{1, 1, 0, 1});
  endtask

  task automatic test_random();
    int budget;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) == 0) begin
        int ch;
        ch = $urandom_range(0, N - 1);
        if (chq[ch].size() < 12) push_pkt(ch, $urandom_range(1, 5));
      end
      run_cycle("random", ($urandom_range(0, 3) != 0), N'($urandom), 1'b0);
    end
    budget = 400;
    while (budget > 0 && (chq[0].size() + chq[1].size() + chq[2].size() + chq[3].size()) > 0) begin
      run_cycle("random_drain", 1'b1, '1, 1'b0);
      budget--;
    end
    check_drained("random");
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_back_to_back();
    test_backpressure();
    test_valid_drop();
    test_reset_mid_packet();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
